// File: rtl/pc_fetch_unit.sv
// -----------------------------------------------------------------------------
// pc_fetch_unit
//   Program-counter register and instruction-fetch sequencer. Issues word
//   fetches over a req/ack handshake, presents the fetched instruction and its
//   PC to decode, and redirects on a branch/jump pulse from execute.
//
// Optional feature macro: PC_ALIGN_CHECK_EN
//   undefined : branch target bits [1:0] are forced to zero, misalign_o is 0.
//   defined   : a misaligned redirect is not taken; the unit parks in TRAP
//               (after any outstanding fetch completes) with misalign_o sticky.
//
// Ports
//   clk, rst_n        core clock, synchronous active-low reset
//   stall_i           decode not ready, hold presented instruction
//   branch_taken_i    one-cycle redirect pulse
//   branch_target_i   redirect target address
//   imem_req_o        fetch request, held until imem_ack_i
//   imem_addr_o       fetch address, stable while request pending
//   imem_ack_i        instruction memory data valid this cycle
//   imem_rdata_i      instruction word
//   instr_valid_o     instr_o / instr_pc_o valid for decode
//   instr_o           fetched instruction
//   instr_pc_o        PC of instr_o
//   misalign_o        misaligned-target trap flag
// -----------------------------------------------------------------------------
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic        misalign_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    FLUSH = 3'd2,
    HOLD  = 3'd3,
    TRAP  = 3'd4
  } state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] STEP      = PC_STEP[31:0];

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] addr_r, addr_s;
  logic        req_r, req_s;
  logic        valid_r, valid_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] instr_pc_r, instr_pc_s;
  logic        misalign_r, misalign_s;
  // Misaligned redirect seen while a fetch is still outstanding: go to TRAP
  // once that fetch is acknowledged.
  logic        trap_pend_r, trap_pend_s;

  logic        bad_tgt_s;
  logic [31:0] tgt_s;

`ifdef PC_ALIGN_CHECK_EN
  assign bad_tgt_s = (branch_target_i[1:0] != 2'b00);
  assign tgt_s     = branch_target_i;
`else
  logic unused_tgt_lsb_s;
  assign unused_tgt_lsb_s = ^branch_target_i[1:0];
  assign bad_tgt_s        = 1'b0;
  assign tgt_s            = {branch_target_i[31:2], 2'b00};
`endif

  // Next-state and next-output computation for the fetch sequencer.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    addr_s      = addr_r;
    valid_s     = valid_r;
    instr_s     = instr_r;
    instr_pc_s  = instr_pc_r;
    misalign_s  = misalign_r;
    trap_pend_s = trap_pend_r;
    case (state_r)
      IDLE: begin
        state_s = FETCH;
        addr_s  = pc_r;
      end
      FETCH: begin
        if (imem_ack_i) begin
          if (branch_taken_i) begin
            // Redirect coincides with the ack: the returned word is squashed.
            if (bad_tgt_s) begin
              state_s    = TRAP;
              misalign_s = 1'b1;
            end else begin
              pc_s    = tgt_s;
              addr_s  = tgt_s;
              state_s = FETCH;
            end
          end else begin
            instr_s    = imem_rdata_i;
            instr_pc_s = addr_r;
            valid_s    = 1'b1;
            state_s    = HOLD;
          end
        end else begin
          if (branch_taken_i) begin
            // Outstanding request must still complete at the old address.
            state_s = FLUSH;
            if (bad_tgt_s) begin
              trap_pend_s = 1'b1;
              misalign_s  = 1'b1;
            end else begin
              pc_s = tgt_s;
            end
          end else begin
            state_s = FETCH;
          end
        end
      end
      FLUSH: begin
        if (imem_ack_i) begin
          if (trap_pend_r) begin
            state_s = TRAP;
          end else if (branch_taken_i && bad_tgt_s) begin
            state_s    = TRAP;
            misalign_s = 1'b1;
          end else if (branch_taken_i) begin
            pc_s    = tgt_s;
            addr_s  = tgt_s;
            state_s = FETCH;
          end else begin
            addr_s  = pc_r;
            state_s = FETCH;
          end
        end else begin
          if (branch_taken_i && !trap_pend_r) begin
            // Last redirect wins.
            if (bad_tgt_s) begin
              trap_pend_s = 1'b1;
              misalign_s  = 1'b1;
            end else begin
              pc_s = tgt_s;
            end
          end else begin
            state_s = FLUSH;
          end
        end
      end
      HOLD: begin
        if (branch_taken_i) begin
          valid_s = 1'b0;
          if (bad_tgt_s) begin
            state_s    = TRAP;
            misalign_s = 1'b1;
          end else begin
            pc_s    = tgt_s;
            addr_s  = tgt_s;
            state_s = FETCH;
          end
        end else if (!stall_i) begin
          valid_s = 1'b0;
          pc_s    = instr_pc_r + STEP;
          addr_s  = instr_pc_r + STEP;
          state_s = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      TRAP: begin
        state_s = TRAP;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Request is asserted exactly while a fetch is pending.
  always_comb begin
    req_s = 1'b0;
    if ((state_s == FETCH) || (state_s == FLUSH)) begin
      req_s = 1'b1;
    end else begin
      req_s = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= RESET_PC;
      addr_r      <= RESET_PC;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
      instr_r     <= NOP_INSTR;
      instr_pc_r  <= RESET_PC;
      misalign_r  <= 1'b0;
      trap_pend_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      addr_r      <= addr_s;
      req_r       <= req_s;
      valid_r     <= valid_s;
      instr_r     <= instr_s;
      instr_pc_r  <= instr_pc_s;
      misalign_r  <= misalign_s;
      trap_pend_r <= trap_pend_s;
    end
  end

  assign imem_req_o    = req_r;
  assign imem_addr_o   = addr_r;
  assign instr_valid_o = valid_r;
  assign instr_o       = instr_r;
  assign instr_pc_o    = instr_pc_r;
  assign misalign_o    = misalign_r;

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        stall;
  logic        branch;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        misalign;

  logic        w_rst_n;
  logic        w_ack;
  logic [31:0] w_rdata;
  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;
  logic        w_misalign;
  logic        w_zero;
  logic [31:0] w_zero32;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(branch),
    .branch_target_i(target), .imem_req_o(req), .imem_addr_o(addr),
    .imem_ack_i(ack), .imem_rdata_i(rdata), .instr_valid_o(valid),
    .instr_o(instr), .instr_pc_o(instr_pc), .misalign_o(misalign)
  );

  pc_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n), .stall_i(w_zero), .branch_taken_i(w_zero),
    .branch_target_i(w_zero32), .imem_req_o(w_req), .imem_addr_o(w_addr),
    .imem_ack_i(w_ack), .imem_rdata_i(w_rdata), .instr_valid_o(w_valid),
    .instr_o(w_instr), .instr_pc_o(w_instr_pc), .misalign_o(w_misalign)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        stall;
    logic        branch;
    logic [31:0] target;
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic a, logic [31:0] d,
                              logic er, logic [31:0] ea, logic ev, logic [31:0] ep,
                              logic [31:0] ei);
    vec_t v;
    v.stall = s; v.branch = b; v.target = t; v.ack = a; v.rdata = d;
    v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep; v.exp_instr = ei;
    return v;
  endfunction

  // Instruction memory contents seen by the bench: a fixed scramble of the address.
  function automatic logic [31:0] mem(logic [31:0] a);
    return (a ^ 32'h5A5A_0000) + 32'h0000_0101;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic reset_main();
    rst_n = 1'b0; stall = 1'b0; branch = 1'b0; target = 32'h0; ack = 1'b0; rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  localparam logic [31:0] NOP = 32'h0000_0013;

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] dlv_pc;
    logic        prev_valid;
    logic        held;
    logic        b;
    logic        st;
    logic [31:0] tgt;
    int          cnt;
    int          deliveries;

    w_zero = 1'b0; w_zero32 = 32'h0; w_rst_n = 1'b0; w_ack = 1'b0; w_rdata = 32'h0;

    // ---------------- reset state ----------------
    reset_main();
    check("reset_req", {31'h0, req}, 32'h0);
    check("reset_addr", addr, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_instr", instr, NOP);
    check("reset_pc", instr_pc, 32'h0);
    check("reset_misalign", {31'h0, misalign}, 32'h0);

    // ---------------- table: sequential, stall, redirects ----------------
    //                 stall branch target        ack   rdata          req  addr          v    pc            instr
    vecs[0]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0000, 1'b0, 32'h0000_0000, NOP);
    vecs[1]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0000, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_0000, 32'hA000_0000);
    vecs[2]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0004, 1'b0, 32'h0000_0000, 32'hA000_0000);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0001, 1'b0, 32'h0000_0004, 1'b1, 32'h0000_0004, 32'hA000_0001);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0008, 1'b0, 32'h0000_0004, 32'hA000_0001);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0002, 1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hA000_0002);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hA000_0002);
    vecs[7]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hA000_0002);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hA000_0002);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hA000_0002);
    vecs[10] = mk(1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0000_0008, 1'b1, 32'h0000_0008, 32'hA000_0002);
    vecs[11] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_000C, 1'b0, 32'h0000_0008, 32'hA000_0002);
    vecs[12] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0003, 1'b0, 32'h0000_000C, 1'b1, 32'h0000_000C, 32'hA000_0003);
    vecs[13] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'hA000_0003);
    vecs[14] = mk(1'b0, 1'b1, 32'h100,      1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'hA000_0003);
    vecs[15] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'hA000_0003);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0010, 1'b0, 32'h0000_000C, 32'hA000_0003);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_000C, 32'hA000_0003);
    vecs[18] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0100, 1'b0, 32'h0000_0100, 1'b1, 32'h0000_0100, 32'hA000_0100);
    vecs[19] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b0, 32'h0000_0100, 32'hA000_0100);
    vecs[20] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0104, 1'b0, 32'h0000_0104, 1'b1, 32'h0000_0104, 32'hA000_0104);
    vecs[21] = mk(1'b1, 1'b1, 32'h200,      1'b0, 32'h0,        1'b1, 32'h0000_0200, 1'b0, 32'h0000_0104, 32'hA000_0104);
    vecs[22] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0200, 1'b0, 32'h0000_0200, 1'b1, 32'h0000_0200, 32'hA000_0200);
    vecs[23] = mk(1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h0000_0204, 1'b0, 32'h0000_0200, 32'hA000_0200);
    vecs[24] = mk(1'b0, 1'b1, 32'h300,      1'b1, 32'hBAD0_0204, 1'b1, 32'h0000_0300, 1'b0, 32'h0000_0200, 32'hA000_0200);
    vecs[25] = mk(1'b0, 1'b0, 32'h0,        1'b1, 32'hA000_0300, 1'b0, 32'h0000_0300, 1'b1, 32'h0000_0300, 32'hA000_0300);

    for (int i = 0; i < 26; i++) begin
      stall = vecs[i].stall; branch = vecs[i].branch; target = vecs[i].target;
      ack = vecs[i].ack; rdata = vecs[i].rdata;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_req", i), {31'h0, req}, {31'h0, vecs[i].exp_req});
      check($sformatf("vec%0d_addr", i), addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_valid", i), {31'h0, valid}, {31'h0, vecs[i].exp_valid});
      check($sformatf("vec%0d_pc", i), instr_pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      check($sformatf("vec%0d_misalign", i), {31'h0, misalign}, 32'h0);
    end
    stall = 1'b0; branch = 1'b0; ack = 1'b0;

    // ---------------- misaligned redirect target 0x102 ----------------
    reset_main();
    @(posedge clk); #1;                 // FETCH at 0
    ack = 1'b1; rdata = mem(32'h0);
    @(posedge clk); #1;                 // HOLD
    ack = 1'b0; stall = 1'b1; branch = 1'b1; target = 32'h0000_0102;
    @(posedge clk); #1;
    branch = 1'b0; stall = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    check("mis_flag", {31'h0, misalign}, 32'h1);
    check("mis_req", {31'h0, req}, 32'h0);
    check("mis_valid", {31'h0, valid}, 32'h0);
    branch = 1'b1; target = 32'h0000_0200; ack = 1'b1;
    repeat (3) @(posedge clk);
    #1 branch = 1'b0; ack = 1'b0;
    check("mis_sticky", {31'h0, misalign}, 32'h1);
    check("mis_req_stuck", {31'h0, req}, 32'h0);
    check("mis_valid_stuck", {31'h0, valid}, 32'h0);
`else
    check("mis_req", {31'h0, req}, 32'h1);
    check("mis_addr", addr, 32'h0000_0100);
    check("mis_flag", {31'h0, misalign}, 32'h0);
    ack = 1'b1; rdata = mem(32'h0000_0100);
    @(posedge clk); #1;
    ack = 1'b0;
    check("mis_valid", {31'h0, valid}, 32'h1);
    check("mis_pc", instr_pc, 32'h0000_0100);
    check("mis_flag_after", {31'h0, misalign}, 32'h0);
`endif

    // ---------------- PC wrap ----------------
    repeat (2) @(posedge clk);
    #1 w_rst_n = 1'b1;
    @(posedge clk); #1;
    check("wrap_req", {31'h0, w_req}, 32'h1);
    check("wrap_addr0", w_addr, 32'hFFFF_FFFC);
    w_ack = 1'b1; w_rdata = 32'h1234_5678;
    @(posedge clk); #1;
    w_ack = 1'b0;
    check("wrap_pc", w_instr_pc, 32'hFFFF_FFFC);
    @(posedge clk); #1;
    check("wrap_addr1", w_addr, 32'h0000_0000);
    check("wrap_req1", {31'h0, w_req}, 32'h1);

    // ---------------- randomized run against program-order model ----------------
    // Model: the next instruction shown to decode is at the last redirect target
    // if any redirect arrived since the previous acceptance, else previous PC + 4.
    reset_main();
    exp_pc = 32'h0; dlv_pc = 32'h0; prev_valid = 1'b0;
    cnt = $urandom_range(0, 3); deliveries = 0;
    for (int c = 0; c < 3000; c++) begin
      b  = (c >= 3) && ($urandom_range(0, 9) == 0);
`ifdef PC_ALIGN_CHECK_EN
      tgt = $urandom & 32'h0000_0FFC;
`else
      tgt = $urandom & 32'h0000_0FFF;
`endif
      st = ($urandom_range(0, 2) == 0);
      if (req) begin
        if (cnt == 0) begin
          ack = 1'b1; rdata = mem(addr); cnt = $urandom_range(0, 3);
        end else begin
          ack = 1'b0; cnt = cnt - 1;
        end
      end else begin
        ack = 1'b0;
      end
      branch = b; target = tgt; stall = st;
      held = valid && st && !b;
      if (b) begin
        exp_pc = tgt & 32'hFFFF_FFFC;
      end else if (valid && !st) begin
        exp_pc = dlv_pc + 32'd4;
      end
      @(posedge clk); #1;
      if (valid && !prev_valid) begin
        check("rnd_pc", instr_pc, exp_pc);
        check("rnd_instr", instr, mem(exp_pc));
        dlv_pc = exp_pc;
        deliveries++;
      end
      if (held) begin
        check("rnd_hold_valid", {31'h0, valid}, 32'h1);
        check("rnd_hold_pc", instr_pc, dlv_pc);
      end
      if (prev_valid && !held) begin
        check("rnd_release", {31'h0, valid}, 32'h0);
      end
      prev_valid = valid;
    end
    branch = 1'b0; ack = 1'b0; stall = 1'b0;
    checks++;
    if (deliveries < 100) begin
      errors++;
      $display("FAIL rnd_progress actual=%0d required>=%0d", deliveries, 100);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
